// File: rtl/fatmeshy_pkg.sv
// Shared fatmeshy link types: credit counter width and credit return mode.
package fatmeshy_pkg;

  localparam int CREDIT_WIDTH = 8;

  typedef logic [CREDIT_WIDTH-1:0] credit_t;

  typedef enum logic {
    CREDIT_INCR,
    CREDIT_ABS
  } credit_mode_e;

endpackage

// File: rtl/vc_credit_scheduler_if.sv
// Transmit request/grant and credit return signals between the router out-port and the credit scheduler.
interface vc_credit_scheduler_if #(
  parameter int NUM_VC       = 4,
  parameter int CREDIT_WIDTH = fatmeshy_pkg::CREDIT_WIDTH
);

  localparam int VCW = $clog2(NUM_VC) | 1;

  // tx_valid[v] is a level request; a word moves on VC v in exactly the cycles where tx_grant[v] is high.
  // Credit returns are single-cycle strobes qualified by credit_valid and need no acknowledge.
  logic [NUM_VC-1:0]       tx_valid;
  logic                    tx_ready;
  logic [NUM_VC-1:0]       tx_grant;
  logic                    credit_valid;
  logic [VCW-1:0]          credit_vc;
  logic [CREDIT_WIDTH-1:0] credit_in;

  modport master (
    output tx_valid, tx_ready, credit_valid, credit_vc, credit_in,
    input  tx_grant
  );

  modport slave (
    input  tx_valid, tx_ready, credit_valid, credit_vc, credit_in,
    output tx_grant
  );

endinterface

// File: rtl/vc_credit_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr, wrapping to the lowest.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N) | 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] gnt_hi;
  logic [N-1:0] gnt_lo;
  logic         hi_found;

  // Scanning downward lets the lowest matching index overwrite earlier picks.
  always_comb begin
    gnt_hi   = '0;
    gnt_lo   = '0;
    hi_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        gnt_lo    = '0;
        gnt_lo[j] = 1'b1;
        if (j >= int'(ptr)) begin
          gnt_hi    = '0;
          gnt_hi[j] = 1'b1;
          hi_found  = 1'b1;
        end
      end
    end
    gnt = hi_found ? gnt_hi : gnt_lo;
  end

endmodule

// File: rtl/vc_credit_scheduler.sv
// Per-link multi-VC credit scheduler: per-VC credit counters, round-robin grant, sticky error flags.
module vc_credit_scheduler
  import fatmeshy_pkg::*;
#(
  parameter int           NUM_VC       = 4,
  parameter int           CREDIT_WIDTH = fatmeshy_pkg::CREDIT_WIDTH,
  parameter int           MAX_CREDITS  = 2**CREDIT_WIDTH - 1,
  parameter int           INIT_CREDITS = 0,
  parameter credit_mode_e CREDIT_MODE  = CREDIT_INCR
) (
  input  logic                           clk,
  input  logic                           rst_n,
  vc_credit_scheduler_if.slave           link,
  output logic [NUM_VC*CREDIT_WIDTH-1:0] credit_count,
  output logic [NUM_VC-1:0]              credit_avail,
  output logic                           err_overflow,
  output logic                           err_vc_range,
  input  logic                           err_clear
);

  localparam int VCW = $clog2(NUM_VC) | 1;
  localparam int CW  = CREDIT_WIDTH;
  localparam int NW  = CREDIT_WIDTH + 1;

  logic [VCW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_VC-1:0] elig, arb_gnt, grant, ovf;
  logic              err_ovf_q, err_ovf_d;
  logic              err_rng_q, err_rng_d;
  logic              vc_bad;

  // Eligibility looks only at registered counts, so a same-cycle return cannot unlock a grant.
  assign elig = link.tx_valid & credit_avail;

  rr_arbiter #(
    .N  (NUM_VC),
    .PW (VCW)
  ) u_arb (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  assign grant         = link.tx_ready ? arb_gnt : '0;
  assign link.tx_grant = grant;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (grant[v]) rr_ptr_d = (v == NUM_VC - 1) ? '0 : VCW'(v + 1);
    end
  end

  assign vc_bad = link.credit_valid && (32'(link.credit_vc) >= NUM_VC);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic          ret;
    logic          dec;
    logic [NW-1:0] nxt;
    logic [CW-1:0] count_q, count_d;

    assign ret = link.credit_valid && (link.credit_vc == VCW'(v));
    assign dec = grant[v];

    // One extra bit of headroom so an over-range result is detectable before clamping.
    always_comb begin
      nxt = '0;
      if (CREDIT_MODE == CREDIT_ABS) begin
        if (ret) nxt = (link.credit_in == '0) ? '0 : ({1'b0, link.credit_in} - NW'(dec));
        else     nxt = {1'b0, count_q} - NW'(dec);
      end else begin
        nxt = {1'b0, count_q} + (ret ? {1'b0, link.credit_in} : '0) - NW'(dec);
      end
    end

    assign ovf[v]  = (nxt > NW'(MAX_CREDITS));
    assign count_d = ovf[v] ? CW'(MAX_CREDITS) : nxt[CW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= CW'(INIT_CREDITS);
      else        count_q <= count_d;
    end

    assign credit_avail[v]             = (count_q != '0);
    assign credit_count[v*CW +: CW]    = count_q;
  end

  // A clear in the same cycle as a new error wins; that error is dropped.
  always_comb begin
    err_ovf_d = err_clear ? 1'b0 : (err_ovf_q | (|ovf));
    err_rng_d = err_clear ? 1'b0 : (err_rng_q | vc_bad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      err_ovf_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      err_ovf_q <= err_ovf_d;
      err_rng_q <= err_rng_d;
    end
  end

  assign err_overflow = err_ovf_q;
  assign err_vc_range = err_rng_q;

endmodule

// File: tb/tb_vc_credit_scheduler.sv
// Directed bench for vc_credit_scheduler: one incremental-mode and one absolute-mode instance.
module tb_vc_credit_scheduler;
  import fatmeshy_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr_a, clr_b;
  logic [31:0] cc_a, cc_b;
  logic [3:0]  av_a, av_b;
  logic        eo_a, eo_b, er_a, er_b;
  int          n_cmp;
  int          n_err;

  vc_credit_scheduler_if #(.NUM_VC(4), .CREDIT_WIDTH(8)) if_a ();
  vc_credit_scheduler_if #(.NUM_VC(4), .CREDIT_WIDTH(8)) if_b ();

  vc_credit_scheduler #(
    .NUM_VC(4), .CREDIT_WIDTH(8), .MAX_CREDITS(200), .INIT_CREDITS(2), .CREDIT_MODE(CREDIT_INCR)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .link(if_a), .credit_count(cc_a), .credit_avail(av_a),
    .err_overflow(eo_a), .err_vc_range(er_a), .err_clear(clr_a)
  );

  vc_credit_scheduler #(
    .NUM_VC(4), .CREDIT_WIDTH(8), .MAX_CREDITS(200), .INIT_CREDITS(2), .CREDIT_MODE(CREDIT_ABS)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .link(if_b), .credit_count(cc_b), .credit_avail(av_b),
    .err_overflow(eo_b), .err_vc_range(er_b), .err_clear(clr_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: apply one cycle of inputs at the falling edge, return 1 time unit later
  task automatic drive_a(input logic [3:0] v, input logic r, input logic cv,
                         input logic [2:0] vc, input logic [7:0] ci, input logic clr);
    @(negedge clk);
    if_a.tx_valid = v; if_a.tx_ready = r; if_a.credit_valid = cv;
    if_a.credit_vc = vc; if_a.credit_in = ci; clr_a = clr;
    #1;
  endtask

  task automatic drive_b(input logic [3:0] v, input logic r, input logic cv,
                         input logic [2:0] vc, input logic [7:0] ci);
    @(negedge clk);
    if_b.tx_valid = v; if_b.tx_ready = r; if_b.credit_valid = cv;
    if_b.credit_vc = vc; if_b.credit_in = ci; clr_b = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (cc_a !== 32'h02020202) begin n_err++; $display("FAIL reset_count: got %h want %h", cc_a, 32'h02020202); end
    n_cmp++; if (av_a !== 4'hF) begin n_err++; $display("FAIL reset_avail: got %h want %h", av_a, 4'hF); end
    n_cmp++; if (if_a.tx_grant !== 4'h0) begin n_err++; $display("FAIL reset_grant: got %h want %h", if_a.tx_grant, 4'h0); end
    n_cmp++; if ({eo_a, er_a} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %b want %b", {eo_a, er_a}, 2'b00); end
    rst_n = 1'b1;
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (cc_a !== 32'h02020202) begin n_err++; $display("FAIL post_reset_count: got %h want %h", cc_a, 32'h02020202); end
    n_cmp++; if (cc_b !== 32'h02020202) begin n_err++; $display("FAIL post_reset_count_b: got %h want %h", cc_b, 32'h02020202); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive_a(4'hF, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
      exp = 4'(1 << i);
      n_cmp++; if (if_a.tx_grant !== exp) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, if_a.tx_grant, exp); end
    end
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (cc_a !== 32'h01010101) begin n_err++; $display("FAIL rr_count: got %h want %h", cc_a, 32'h01010101); end
    n_cmp++; if (av_a !== 4'hF) begin n_err++; $display("FAIL rr_avail: got %h want %h", av_a, 4'hF); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      drive_a(4'hF, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
      n_cmp++; if (if_a.tx_grant !== 4'h0) begin n_err++; $display("FAIL bp_grant%0d: got %b want %b", i, if_a.tx_grant, 4'h0); end
      n_cmp++; if (cc_a !== 32'h01010101) begin n_err++; $display("FAIL bp_count%0d: got %h want %h", i, cc_a, 32'h01010101); end
    end
    drive_a(4'b1010, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (if_a.tx_grant !== 4'b0010) begin n_err++; $display("FAIL bp_grant_vc1: got %b want %b", if_a.tx_grant, 4'b0010); end
    drive_a(4'hF, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (cc_a !== 32'h01010001) begin n_err++; $display("FAIL bp_count_vc1: got %h want %h", cc_a, 32'h01010001); end
    drive_a(4'hF, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (if_a.tx_grant !== 4'h0) begin n_err++; $display("FAIL bp_hold_grant: got %b want %b", if_a.tx_grant, 4'h0); end
    // pointer must have held at 2 through the stalled cycles, so VC3 beats VC0
    drive_a(4'b1001, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (if_a.tx_grant !== 4'b1000) begin n_err++; $display("FAIL bp_ptr_hold: got %b want %b", if_a.tx_grant, 4'b1000); end
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (cc_a !== 32'h00010001) begin n_err++; $display("FAIL bp_count_end: got %h want %h", cc_a, 32'h00010001); end
    n_cmp++; if (av_a !== 4'b0101) begin n_err++; $display("FAIL bp_avail_end: got %b want %b", av_a, 4'b0101); end
  endtask

  task automatic test_credit_starvation();
    drive_a(4'h1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (if_a.tx_grant !== 4'b0001) begin n_err++; $display("FAIL st_drain: got %b want %b", if_a.tx_grant, 4'b0001); end
    drive_a(4'h1, 1'b1, 1'b1, 3'd0, 8'd3, 1'b0);
    n_cmp++; if (if_a.tx_grant !== 4'h0) begin n_err++; $display("FAIL st_return_cycle: got %b want %b", if_a.tx_grant, 4'h0); end
    for (int k = 1; k <= 3; k++) begin
      drive_a(4'h1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
      n_cmp++; if (if_a.tx_grant !== 4'b0001) begin n_err++; $display("FAIL st_grant_t%0d: got %b want %b", k, if_a.tx_grant, 4'b0001); end
    end
    drive_a(4'h1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (if_a.tx_grant !== 4'h0) begin n_err++; $display("FAIL st_grant_t4: got %b want %b", if_a.tx_grant, 4'h0); end
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (cc_a !== 32'h00010000) begin n_err++; $display("FAIL st_count: got %h want %h", cc_a, 32'h00010000); end
    n_cmp++; if (av_a !== 4'b0100) begin n_err++; $display("FAIL st_avail: got %b want %b", av_a, 4'b0100); end
  endtask

  task automatic test_simultaneous();
    drive_a(4'b0100, 1'b1, 1'b1, 3'd2, 8'd5, 1'b0);
    n_cmp++; if (if_a.tx_grant !== 4'b0100) begin n_err++; $display("FAIL sim_incr_grant: got %b want %b", if_a.tx_grant, 4'b0100); end
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (cc_a !== 32'h00050000) begin n_err++; $display("FAIL sim_incr_count: got %h want %h", cc_a, 32'h00050000); end
    drive_b(4'b0100, 1'b1, 1'b0, 3'd0, 8'd0);
    n_cmp++; if (if_b.tx_grant !== 4'b0100) begin n_err++; $display("FAIL abs_pre_grant: got %b want %b", if_b.tx_grant, 4'b0100); end
    drive_b(4'b0100, 1'b1, 1'b1, 3'd2, 8'd5);
    n_cmp++; if (cc_b !== 32'h02010202) begin n_err++; $display("FAIL abs_pre_count: got %h want %h", cc_b, 32'h02010202); end
    n_cmp++; if (if_b.tx_grant !== 4'b0100) begin n_err++; $display("FAIL abs_sim_grant: got %b want %b", if_b.tx_grant, 4'b0100); end
    drive_b(4'h0, 1'b0, 1'b0, 3'd0, 8'd0);
    n_cmp++; if (cc_b !== 32'h02040202) begin n_err++; $display("FAIL abs_sim_count: got %h want %h", cc_b, 32'h02040202); end
    drive_b(4'b0100, 1'b1, 1'b1, 3'd2, 8'd0);
    drive_b(4'h0, 1'b0, 1'b1, 3'd0, 8'd7);
    n_cmp++; if (cc_b !== 32'h02000202) begin n_err++; $display("FAIL abs_zero_count: got %h want %h", cc_b, 32'h02000202); end
    drive_b(4'h0, 1'b0, 1'b0, 3'd0, 8'd0);
    n_cmp++; if (cc_b !== 32'h02000207) begin n_err++; $display("FAIL abs_replace: got %h want %h", cc_b, 32'h02000207); end
    n_cmp++; if (av_b !== 4'b1011) begin n_err++; $display("FAIL abs_avail: got %b want %b", av_b, 4'b1011); end
  endtask

  task automatic test_saturation();
    drive_a(4'h0, 1'b0, 1'b1, 3'd1, 8'd150, 1'b0);
    drive_a(4'h0, 1'b0, 1'b1, 3'd3, 8'd200, 1'b0);
    n_cmp++; if (cc_a !== 32'h00059600) begin n_err++; $display("FAIL sat_add150: got %h want %h", cc_a, 32'h00059600); end
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (cc_a !== 32'hC8059600) begin n_err++; $display("FAIL sat_exact_max: got %h want %h", cc_a, 32'hC8059600); end
    n_cmp++; if (eo_a !== 1'b0) begin n_err++; $display("FAIL sat_exact_no_ovf: got %b want %b", eo_a, 1'b0); end
    drive_a(4'h0, 1'b0, 1'b1, 3'd1, 8'd100, 1'b0);
    drive_a(4'h0, 1'b0, 1'b1, 3'd5, 8'd9, 1'b0);
    n_cmp++; if (cc_a !== 32'hC805C800) begin n_err++; $display("FAIL sat_clamp: got %h want %h", cc_a, 32'hC805C800); end
    n_cmp++; if (eo_a !== 1'b1) begin n_err++; $display("FAIL sat_ovf_flag: got %b want %b", eo_a, 1'b1); end
    n_cmp++; if (er_a !== 1'b0) begin n_err++; $display("FAIL sat_rng_early: got %b want %b", er_a, 1'b0); end
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (cc_a !== 32'hC805C800) begin n_err++; $display("FAIL rng_counts_hold: got %h want %h", cc_a, 32'hC805C800); end
    n_cmp++; if (er_a !== 1'b1) begin n_err++; $display("FAIL rng_flag: got %b want %b", er_a, 1'b1); end
    n_cmp++; if (eo_a !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want %b", eo_a, 1'b1); end
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
    drive_a(4'h0, 1'b0, 1'b1, 3'd6, 8'd1, 1'b1);
    n_cmp++; if ({eo_a, er_a} !== 2'b00) begin n_err++; $display("FAIL clear_flags: got %b want %b", {eo_a, er_a}, 2'b00); end
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if ({eo_a, er_a} !== 2'b00) begin n_err++; $display("FAIL clear_priority: got %b want %b", {eo_a, er_a}, 2'b00); end
    n_cmp++; if (cc_a !== 32'hC805C800) begin n_err++; $display("FAIL clear_counts: got %h want %h", cc_a, 32'hC805C800); end
  endtask

  task automatic test_reset_midburst();
    drive_a(4'hF, 1'b1, 1'b1, 3'd7, 8'd1, 1'b0);
    n_cmp++; if (if_a.tx_grant !== 4'b1000) begin n_err++; $display("FAIL mid_grant0: got %b want %b", if_a.tx_grant, 4'b1000); end
    drive_a(4'hF, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (if_a.tx_grant !== 4'b0010) begin n_err++; $display("FAIL mid_grant1: got %b want %b", if_a.tx_grant, 4'b0010); end
    n_cmp++; if (cc_a !== 32'hC705C800) begin n_err++; $display("FAIL mid_count: got %h want %h", cc_a, 32'hC705C800); end
    n_cmp++; if (er_a !== 1'b1) begin n_err++; $display("FAIL mid_rng: got %b want %b", er_a, 1'b1); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (cc_a !== 32'h02020202) begin n_err++; $display("FAIL mid_rst_count: got %h want %h", cc_a, 32'h02020202); end
    n_cmp++; if ({eo_a, er_a} !== 2'b00) begin n_err++; $display("FAIL mid_rst_errs: got %b want %b", {eo_a, er_a}, 2'b00); end
    n_cmp++; if (if_a.tx_grant !== 4'b0001) begin n_err++; $display("FAIL mid_rst_grant: got %b want %b", if_a.tx_grant, 4'b0001); end
    @(posedge clk); #1;
    n_cmp++; if (cc_a !== 32'h02020202) begin n_err++; $display("FAIL mid_rst_hold: got %h want %h", cc_a, 32'h02020202); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    n_cmp++; if (av_a !== 4'hF) begin n_err++; $display("FAIL mid_rst_avail: got %b want %b", av_a, 4'hF); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    if_a.tx_valid = '0; if_a.tx_ready = 1'b0; if_a.credit_valid = 1'b0; if_a.credit_vc = '0; if_a.credit_in = '0;
    if_b.tx_valid = '0; if_b.tx_ready = 1'b0; if_b.credit_valid = 1'b0; if_b.credit_vc = '0; if_b.credit_in = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_credit_starvation();
    test_simultaneous();
    test_saturation();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
